// File: rtl/ad7606_sample_scheduler.sv
// ad7606_sample_scheduler
//
// Sequences AD7606 acquisitions. A capture is armed by i_start, optionally
// waits for a trigger, then issues one conversion request per sample period
// until the sample quota is met or the capture is stopped. Sits between the
// command decoder (config/start/trigger) and the AD7606 driver (conversion
// request/done handshake). Owns the capture-enable level and the channel mask
// seen by the packetiser, and reports overrun and completion.
//
// Optional build macro:
//   AD_SCHED_TRIG_SYNC_EN  - i_ext_trig goes through a 2-flop synchroniser
//                            before edge detection (trigger-to-RUN latency of
//                            3 cycles instead of 1).
//
// Ports:
//   i_clk, i_rst_n     clock, synchronous active-low reset
//   i_system_run       0 forces IDLE and clears all outputs (like reset)
//   i_cfg_period       clocks between conversion requests (clamped to
//                      P_MIN_PERIOD)
//   i_cfg_chnl_mask    enabled channels, latched at start
//   i_cfg_samples      samples per capture, 0 = continuous
//   i_cfg_trig_mode    0 immediate, 1 software, 2 ext rising, 3 ext falling
//   i_start, i_stop    1-cycle start / abort pulses
//   i_soft_trig        1-cycle software trigger
//   i_ext_trig         external trigger pin level
//   o_conv_req         1-cycle conversion request to the driver
//   i_conv_done        1-cycle "sample read out" pulse from the driver
//   o_cap_enable       high from RUN entry until IDLE re-entry
//   o_chnl_mask        mask latched at start
//   o_sample_cnt       completed samples in current capture (saturating)
//   o_busy             FSM not in IDLE
//   o_done             1-cycle pulse on completion or abort
//   o_overrun          sticky: period elapsed with a conversion outstanding
//   o_state            FSM state for debug/observation
//
// Handshake: o_conv_req and i_conv_done are single-cycle pulses. At most one
// conversion is outstanding; a request sets the outstanding flag and the next
// i_conv_done clears it. i_conv_done with nothing outstanding is ignored.

module ad7606_sample_scheduler #(
    parameter int P_MIN_PERIOD = 4,
    parameter int P_CNT_W      = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_system_run,
    input  logic [23:0]        i_cfg_period,
    input  logic [7:0]         i_cfg_chnl_mask,
    input  logic [P_CNT_W-1:0] i_cfg_samples,
    input  logic [1:0]         i_cfg_trig_mode,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_soft_trig,
    input  logic               i_ext_trig,
    output logic               o_conv_req,
    input  logic               i_conv_done,
    output logic               o_cap_enable,
    output logic [7:0]         o_chnl_mask,
    output logic [P_CNT_W-1:0] o_sample_cnt,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_overrun,
    output logic [2:0]         o_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TRIG = 3'd1,
        S_RUN       = 3'd2,
        S_DRAIN     = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    localparam logic [23:0]        MIN_PERIOD = 24'(P_MIN_PERIOD);
    localparam logic [P_CNT_W-1:0] CNT_ONE    = P_CNT_W'(1);

    state_t               state;
    state_t               state_nxt;
    logic [23:0]          period_q;
    logic [23:0]          period_cnt;
    logic [P_CNT_W-1:0]   quota_q;
    logic [1:0]           mode_q;
    logic                 outstanding;
    logic                 ext_s;
    logic                 ext_prev;
    logic                 ext_rise;
    logic                 ext_fall;
    logic                 tick;
    logic                 done_ok;
    logic                 quota_hit;
    logic                 start_ok;
    logic                 conv_req;
    logic                 soft_rst;

    // i_system_run low behaves exactly like reset.
    assign soft_rst = !i_rst_n || !i_system_run;

`ifdef AD_SCHED_TRIG_SYNC_EN
    logic [1:0] ext_sync;

    always_ff @(posedge i_clk) begin
        if (soft_rst) begin
            ext_sync <= '0;
        end else begin
            ext_sync <= {ext_sync[0], i_ext_trig};
        end
    end

    assign ext_s = ext_sync[1];
`else
    assign ext_s = i_ext_trig;
`endif

    assign ext_rise = ext_s && !ext_prev;
    assign ext_fall = !ext_s && ext_prev;

    // The period counter sits at 0 outside RUN, so the first RUN cycle is a
    // tick and issues the first request immediately.
    assign tick      = (state == S_RUN) && (period_cnt == 24'd0);
    assign done_ok   = i_conv_done && outstanding;
    assign quota_hit = (quota_q != '0) && ((o_sample_cnt + CNT_ONE) == quota_q);
    assign start_ok  = (state == S_IDLE) && i_start && !i_stop;

    always_ff @(posedge i_clk) begin
        if (soft_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        conv_req  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_nxt = (i_cfg_trig_mode == 2'd0) ? S_RUN : S_WAIT_TRIG;
                end
            end
            S_WAIT_TRIG: begin
                if (i_stop) begin
                    state_nxt = S_DONE;
                end else begin
                    case (mode_q)
                        2'd1:    if (i_soft_trig) state_nxt = S_RUN;
                        2'd2:    if (ext_rise)    state_nxt = S_RUN;
                        2'd3:    if (ext_fall)    state_nxt = S_RUN;
                        default: state_nxt = S_RUN;
                    endcase
                end
            end
            S_RUN: begin
                if (i_stop) begin
                    // A done arriving with the stop settles the outstanding
                    // conversion, so there is nothing left to drain.
                    state_nxt = (outstanding && !i_conv_done) ? S_DRAIN : S_DONE;
                end else if (done_ok && quota_hit) begin
                    state_nxt = S_DONE;
                end else if (tick && !outstanding) begin
                    conv_req = 1'b1;
                end
            end
            S_DRAIN: begin
                if (done_ok) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (soft_rst) begin
            period_q     <= '0;
            period_cnt   <= '0;
            quota_q      <= '0;
            mode_q       <= '0;
            outstanding  <= 1'b0;
            ext_prev     <= 1'b0;
            o_chnl_mask  <= '0;
            o_sample_cnt <= '0;
            o_overrun    <= 1'b0;
            o_cap_enable <= 1'b0;
        end else begin
            ext_prev <= ext_s;

            if (start_ok) begin
                period_q     <= (i_cfg_period < MIN_PERIOD) ? MIN_PERIOD : i_cfg_period;
                o_chnl_mask  <= i_cfg_chnl_mask;
                quota_q      <= i_cfg_samples;
                mode_q       <= i_cfg_trig_mode;
                o_sample_cnt <= '0;
                o_overrun    <= 1'b0;
                outstanding  <= 1'b0;
            end else begin
                if (conv_req) begin
                    outstanding <= 1'b1;
                end else if (done_ok) begin
                    outstanding <= 1'b0;
                end
                if (done_ok && (o_sample_cnt != '1)) begin
                    o_sample_cnt <= o_sample_cnt + CNT_ONE;
                end
                // Missed period: skip the request, flag it, keep the cadence.
                if (tick && outstanding && !i_stop) begin
                    o_overrun <= 1'b1;
                end
            end

            if (state == S_RUN) begin
                period_cnt <= tick ? (period_q - 24'd1) : (period_cnt - 24'd1);
            end else begin
                period_cnt <= '0;
            end

            if ((state_nxt == S_RUN) && (state != S_RUN)) begin
                o_cap_enable <= 1'b1;
            end else if (state_nxt == S_IDLE) begin
                o_cap_enable <= 1'b0;
            end
        end
    end

    assign o_conv_req = conv_req;
    assign o_busy     = (state != S_IDLE);
    assign o_done     = (state == S_DONE);
    assign o_state    = state;

endmodule

// File: tb/tb_ad7606_sample_scheduler.sv
// Testbench for ad7606_sample_scheduler.
// Expected o_conv_req / o_done events are computed from the capture rules
// (request times start+1+k*period, completion one cycle after the final
// conversion-done) and queued as {is_req, cycle}; a monitor pops and compares
// whenever the DUT pulses either output. A responder plays the AD7606 driver.

module tb_ad7606_sample_scheduler;

  localparam int CNT_W = 16;

`ifdef AD_SCHED_TRIG_SYNC_EN
  localparam int TRIG_LAT = 3;
`else
  localparam int TRIG_LAT = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             rst_n;
  logic             system_run;
  logic [23:0]      cfg_period;
  logic [7:0]       cfg_chnl_mask;
  logic [CNT_W-1:0] cfg_samples;
  logic [1:0]       cfg_trig_mode;
  logic             start;
  logic             stop;
  logic             soft_trig;
  logic             ext_trig;
  logic             conv_req;
  logic             conv_done = 1'b0;
  logic             cap_enable;
  logic [7:0]       chnl_mask;
  logic [CNT_W-1:0] sample_cnt;
  logic             busy;
  logic             done;
  logic             overrun;
  logic [2:0]       state_dbg;

  ad7606_sample_scheduler #(.P_MIN_PERIOD(4), .P_CNT_W(CNT_W)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_system_run    (system_run),
    .i_cfg_period    (cfg_period),
    .i_cfg_chnl_mask (cfg_chnl_mask),
    .i_cfg_samples   (cfg_samples),
    .i_cfg_trig_mode (cfg_trig_mode),
    .i_start         (start),
    .i_stop          (stop),
    .i_soft_trig     (soft_trig),
    .i_ext_trig      (ext_trig),
    .o_conv_req      (conv_req),
    .i_conv_done     (conv_done),
    .o_cap_enable    (cap_enable),
    .o_chnl_mask     (chnl_mask),
    .o_sample_cnt    (sample_cnt),
    .o_busy          (busy),
    .o_done          (done),
    .o_overrun       (overrun),
    .o_state         (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          due_q[$];
  int          done_lat = 5;
  bit          withhold = 1'b0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_ev(input bit is_req, input int c);
    logic [31:0] c32;
    c32 = c;
    exp_q.push_back({is_req, c32[30:0]});
  endfunction

  function automatic void insert_due(input int c);
    int i = 0;
    while (i < due_q.size() && due_q[i] <= c) i++;
    due_q.insert(i, c);
  endfunction

  task automatic check_ev(input logic [31:0] act);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: unexpected %s at cycle %0d, none expected",
               act[31] ? "conv_req" : "done", act[30:0]);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL event: got %s at cycle %0d expected %s at cycle %0d",
                 act[31] ? "conv_req" : "done", act[30:0],
                 e[31] ? "conv_req" : "done", e[30:0]);
      end
    end
  endtask

  // ---------------- monitor (samples on the inactive edge) ----------------
  always @(negedge clk) begin
    logic [31:0] c32;
    c32 = cyc;
    if (rst_n === 1'b1) begin
      if (conv_req === 1'b1) begin
        if (!withhold) insert_due(cyc + done_lat);
        check_ev({1'b1, c32[30:0]});
      end
      if (done === 1'b1) check_ev({1'b0, c32[30:0]});
    end
  end

  // ---------------- AD7606 driver model ----------------
  always @(posedge clk) begin
    #1;
    conv_done = 1'b0;
    while (due_q.size() > 0 && due_q[0] < cyc) void'(due_q.pop_front());
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      conv_done = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic start_cap(input logic [1:0] mode, input logic [23:0] period,
                           input logic [7:0] mask, input logic [CNT_W-1:0] quota);
    cfg_trig_mode = mode;
    cfg_period    = period;
    cfg_chnl_mask = mask;
    cfg_samples   = quota;
    start         = 1'b1;
    step();
    start         = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  function automatic int clamp_period(input int p);
    return (p < 4) ? 4 : p;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_conv_req"},   conv_req,   0);
    chk({tag, "_cap_enable"}, cap_enable, 0);
    chk({tag, "_mask"},       chnl_mask,  0);
    chk({tag, "_cnt"},        sample_cnt, 0);
    chk({tag, "_busy"},       busy,       0);
    chk({tag, "_done"},       done,       0);
    chk({tag, "_overrun"},    overrun,    0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s, t0, pc, praw, lat, q, e;
    logic [7:0] m;

    rst_n = 1'b0; system_run = 1'b1;
    cfg_period = '0; cfg_chnl_mask = '0; cfg_samples = '0; cfg_trig_mode = '0;
    start = 1'b0; stop = 1'b0; soft_trig = 1'b0; ext_trig = 1'b0;
    repeat (4) step();
    rst_n = 1'b1;
    step();
    check_idle_outputs("reset");

    // Immediate mode, period 10, quota 3, done 5 clocks after each request.
    done_lat = 5;
    s = cyc;
    push_ev(1, s + 1); push_ev(1, s + 11); push_ev(1, s + 21); push_ev(0, s + 27);
    chk("t1_cap_before", cap_enable, 0);
    start_cap(2'd0, 24'd10, 8'hA5, 16'd3);
    chk("t1_cap_first_req", cap_enable, 1);
    go_to(s + 24);
    chk("t1_busy", busy, 1);
    chk("t1_mask", chnl_mask, 8'hA5);
    go_to(s + 30);
    chk("t1_cnt", sample_cnt, 3);
    chk("t1_idle", busy, 0);
    chk("t1_cap_after", cap_enable, 0);
    chk("t1_drained", exp_q.size(), 0);

    // Randomised immediate captures, including periods below the minimum.
    for (int i = 0; i < 8; i++) begin
      praw = $urandom_range(0, 20);
      pc   = clamp_period(praw);
      lat  = $urandom_range(1, pc - 1);
      q    = $urandom_range(1, 4);
      m    = 8'($urandom_range(0, 255));
      done_lat = lat;
      s = cyc;
      for (int k = 0; k < q; k++) push_ev(1, s + 1 + k * pc);
      push_ev(0, s + 1 + (q - 1) * pc + lat + 1);
      start_cap(2'd0, 24'(praw), m, 16'(q));
      go_to(s + 1 + (q - 1) * pc + lat + 4);
      chk("rnd_cnt", sample_cnt, q);
      chk("rnd_idle", busy, 0);
      chk("rnd_overrun", overrun, 0);
      chk("rnd_mask", chnl_mask, m);
      chk("rnd_drained", exp_q.size(), 0);
    end

    // External rising trigger; a falling edge beforehand must be ignored.
    done_lat = 3;
    ext_trig = 1'b1;
    repeat (4) step();
    s = cyc; e = 20;
    push_ev(1, s + e + TRIG_LAT); push_ev(0, s + e + TRIG_LAT + 4);
    start_cap(2'd2, 24'd8, 8'h0F, 16'd1);
    go_to(s + 5);
    ext_trig = 1'b0;
    go_to(s + e - 2);
    chk("t2_waiting_busy", busy, 1);
    chk("t2_waiting_cap", cap_enable, 0);
    go_to(s + e);
    ext_trig = 1'b1;
    go_to(s + e + TRIG_LAT + 8);
    chk("t2_cnt", sample_cnt, 1);
    chk("t2_drained", exp_q.size(), 0);

    // External falling trigger; a rising edge beforehand must be ignored.
    ext_trig = 1'b0;
    repeat (4) step();
    s = cyc; e = 12;
    push_ev(1, s + e + TRIG_LAT); push_ev(0, s + e + TRIG_LAT + 4);
    start_cap(2'd3, 24'd8, 8'h0F, 16'd1);
    go_to(s + 4);
    ext_trig = 1'b1;
    go_to(s + e);
    ext_trig = 1'b0;
    go_to(s + e + TRIG_LAT + 8);
    chk("t2b_drained", exp_q.size(), 0);

    // Software trigger.
    s = cyc;
    push_ev(1, s + 9); push_ev(0, s + 13);
    start_cap(2'd1, 24'd8, 8'h33, 16'd1);
    go_to(s + 8);
    soft_trig = 1'b1;
    step();
    soft_trig = 1'b0;
    go_to(s + 20);
    chk("soft_drained", exp_q.size(), 0);

    // Stop while waiting for a trigger: done pulse, capture never enabled.
    s = cyc;
    push_ev(0, s + 4);
    start_cap(2'd1, 24'd8, 8'h33, 16'd1);
    go_to(s + 3);
    pulse_stop();
    chk("wstop_cap", cap_enable, 0);
    go_to(s + 8);
    chk("wstop_cnt", sample_cnt, 0);
    chk("wstop_drained", exp_q.size(), 0);

    // Overrun: first done withheld 15 clocks, so the second tick is skipped.
    withhold = 1'b1;
    s = cyc; t0 = s + 1;
    push_ev(1, t0); push_ev(1, t0 + 20); push_ev(0, t0 + 26);
    insert_due(t0 + 15); insert_due(t0 + 23);
    start_cap(2'd0, 24'd10, 8'h11, 16'd0);
    go_to(t0 + 10);
    chk("ovr_before", overrun, 0);
    go_to(t0 + 11);
    chk("ovr_set", overrun, 1);
    go_to(t0 + 24);
    start = 1'b1;            // start outside IDLE is ignored
    step();
    start = 1'b0;
    pulse_stop();            // nothing outstanding: straight to DONE
    go_to(t0 + 30);
    chk("ovr_cnt", sample_cnt, 2);
    chk("ovr_sticky", overrun, 1);
    chk("ovr_drained", exp_q.size(), 0);
    withhold = 1'b0;

    // Continuous capture stopped with a conversion outstanding: drain.
    done_lat = 5;
    s = cyc; t0 = s + 1;
    push_ev(1, t0); push_ev(1, t0 + 10); push_ev(0, t0 + 16);
    start_cap(2'd0, 24'd10, 8'h22, 16'd0);
    chk("drain_ovr_cleared", overrun, 0);
    go_to(t0 + 12);
    pulse_stop();
    go_to(t0 + 14);
    chk("drain_busy", busy, 1);
    chk("drain_cap", cap_enable, 1);
    go_to(t0 + 20);
    chk("drain_cnt", sample_cnt, 2);
    chk("drain_idle", busy, 0);
    chk("drain_drained", exp_q.size(), 0);

    // System run dropped mid-capture.
    s = cyc; t0 = s + 1;
    push_ev(1, t0);
    start_cap(2'd0, 24'd10, 8'h44, 16'd0);
    go_to(t0 + 3);
    system_run = 1'b0;
    go_to(t0 + 4);
    check_idle_outputs("sysrun");
    go_to(t0 + 6);
    system_run = 1'b1;
    go_to(t0 + 12);
    chk("sysrun_drained", exp_q.size(), 0);

    // Start and stop in the same IDLE cycle: start ignored.
    cfg_trig_mode = 2'd0; cfg_period = 24'd6; cfg_samples = 16'd1;
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    repeat (3) step();
    chk("startstop_busy", busy, 0);
    chk("startstop_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    errors++;
    checks++;
    $display("FAIL timeout: simulation did not complete at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
